// File: rtl/vector_uram_pkg.sv
// Shared constants for the vector URAM bank: read modes, FSM encoding, rotate-index sizing.
// Pure declarations; no timing or flow control of its own.
package vector_uram_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_INC    = 2'd1,
      MODE_DEC    = 2'd2,
      MODE_ROT    = 2'd3
   } mode_e;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // A single-lane word still needs a 1-bit (always zero) rotate index.
   function automatic int rot_idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/uram_sdp.sv
// Simple dual-port URAM-style store: one write, one read-first read, RD_LAT output registers.
// Read latency RD_LAT cycles; last stage loads only on i_oce so it holds; no backpressure.
module uram_sdp #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic              i_oce,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0]             r_mem [0:(1<<ADDR_W)-1];
   logic [RD_LAT-1:0][DATA_W-1:0] r_pipe;
   logic [RD_LAT-1:0][DATA_W-1:0] w_pipe_in;
   logic [DATA_W-1:0]             w_rd;

   // Array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign w_rd = r_mem[i_raddr];

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign w_pipe_in = w_rd;
      end else begin : g_latn
         assign w_pipe_in = {r_pipe[RD_LAT-2:0], w_rd};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pipe <= '0;
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            if ((i != RD_LAT-1) || i_oce) begin
               r_pipe[i] <= w_pipe_in[i];
            end
         end
      end
   end

   assign o_rdata = r_pipe[RD_LAT-1];

endmodule

// File: rtl/vector_uram_bank.sv
// Vector store with direct reads and inc/dec/lane-rotate burst sweeps over a URAM bank.
// Read latency RD_LAT cycles, bursts back-to-back; no backpressure, busy gates new bursts.
module vector_uram_bank
   import vector_uram_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 2,
   parameter int LANE_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] host_write_addr,
   input  logic [ADDR_W-1:0] host_read_addr,
   input  logic [1:0]        mod,
   input  logic [ADDR_W-1:0] burst_len,
   input  logic              en_read,
   output logic [DATA_W-1:0] out_number,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int NLANES = DATA_W / LANE_W;
   localparam int ROT_W  = rot_idx_w(NLANES);

   logic [0:0]                   r_state;
   mode_e                        r_mode;
   logic [ADDR_W-1:0]            r_addr;
   logic [ADDR_W:0]              r_beats;
   logic [ROT_W-1:0]             r_rot;
   logic [RD_LAT-1:0]            r_vld_pipe;
   logic [RD_LAT-1:0]            r_last_pipe;
   logic [RD_LAT-1:0][ROT_W-1:0] r_rot_pipe;

   logic [ADDR_W-1:0]            w_rd_addr;
   logic                         w_iss_vld;
   logic                         w_iss_last;
   logic [ROT_W-1:0]             w_iss_rot;
   logic [RD_LAT-1:0]            w_vld_in;
   logic [RD_LAT-1:0]            w_last_in;
   logic [RD_LAT-1:0][ROT_W-1:0] w_rot_in;
   logic [DATA_W-1:0]            w_mem_dout;
   logic [DATA_W-1:0]            w_rot_dat;
   logic                         w_last_beat;

   always_comb begin
      w_rd_addr  = host_read_addr;
      w_iss_vld  = (mod == MODE_DIRECT);
      w_iss_last = 1'b0;
      w_iss_rot  = '0;
      if (r_state == ST_BURST) begin
         w_rd_addr  = r_addr;
         w_iss_vld  = (r_beats != '0);
         w_iss_last = (r_beats == (ADDR_W+1)'(1));
         if (r_mode == MODE_ROT) begin
            w_iss_rot = r_rot;
         end
      end
   end

   assign w_last_beat = r_vld_pipe[RD_LAT-1] & r_last_pipe[RD_LAT-1];

   // The FSM stays in BURST while beats drain so busy covers the last output beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_DIRECT;
         r_addr  <= '0;
         r_beats <= '0;
         r_rot   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en_read && (mod != MODE_DIRECT)) begin
                  r_state <= ST_BURST;
                  r_mode  <= mode_e'(mod);
                  r_addr  <= host_read_addr;
                  r_beats <= {1'b0, burst_len} + (ADDR_W+1)'(1);
                  r_rot   <= '0;
               end
            end
            default: begin
               if (r_beats != '0) begin
                  r_beats <= r_beats - (ADDR_W+1)'(1);
                  r_addr  <= (r_mode == MODE_DEC) ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
                  r_rot   <= (r_rot == ROT_W'(NLANES-1)) ? '0 : (r_rot + ROT_W'(1));
               end
               if (w_last_beat) begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   generate
      if (RD_LAT == 1) begin : g_tag1
         assign w_vld_in  = w_iss_vld;
         assign w_last_in = w_iss_last;
         assign w_rot_in  = w_iss_rot;
      end else begin : g_tagn
         assign w_vld_in  = {r_vld_pipe[RD_LAT-2:0], w_iss_vld};
         assign w_last_in = {r_last_pipe[RD_LAT-2:0], w_iss_last};
         assign w_rot_in  = {r_rot_pipe[RD_LAT-2:0], w_iss_rot};
      end
   endgenerate

   // Final rotate stage holds with the memory output so out_number stays stable between beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_rot_pipe  <= '0;
      end else begin
         r_vld_pipe  <= w_vld_in;
         r_last_pipe <= w_last_in;
         for (int i = 0; i < RD_LAT-1; i++) begin
            r_rot_pipe[i] <= w_rot_in[i];
         end
         if (w_vld_in[RD_LAT-1]) begin
            r_rot_pipe[RD_LAT-1] <= w_rot_in[RD_LAT-1];
         end
      end
   end

   uram_sdp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (wr_en),
      .i_waddr (host_write_addr),
      .i_wdata (data_in),
      .i_raddr (w_rd_addr),
      .i_oce   (w_vld_in[RD_LAT-1]),
      .o_rdata (w_mem_dout)
   );

   always_comb begin
      w_rot_dat = '0;
      for (int j = 0; j < NLANES; j++) begin
         w_rot_dat[j*LANE_W +: LANE_W] =
            w_mem_dout[((j + NLANES - int'(r_rot_pipe[RD_LAT-1])) % NLANES)*LANE_W +: LANE_W];
      end
   end

   assign out_number = w_rot_dat;
   assign out_valid  = r_vld_pipe[RD_LAT-1];
   assign busy       = (r_state == ST_BURST);
   assign done       = w_last_beat;

endmodule

// File: tb/tb_vector_uram_bank.sv
// Directed bench for vector_uram_bank: per-cycle vector table plus reset and mid-burst reset sequences.
module tb_vector_uram_bank;

   localparam logic [255:0] Z   = '0;
   localparam logic [255:0] D0  = 256'h0000a5a5;
   localparam logic [255:0] D1  = 256'h0000ffff;
   localparam logic [255:0] D2  = 256'h0abcffff;
   localparam logic [255:0] D3  = 256'hffff0000;
   localparam logic [255:0] D4  = 256'h12345678;
   localparam logic [255:0] D63 = 256'h00003f3f;
   localparam logic [255:0] ONE = 256'h1;
   localparam logic [255:0] R   = {64'h4, 64'h3, 64'h2, 64'h1};
   localparam logic [255:0] RR  = {64'h3, 64'h2, 64'h1, 64'h4};

   typedef struct {
      logic         wr;
      logic [5:0]   wa;
      logic [255:0] wd;
      logic [5:0]   ra;
      logic [1:0]   md;
      logic [5:0]   bl;
      logic         en;
      logic         ev;
      logic         eb;
      logic         ed;
      logic         cd;
      logic [255:0] edat;
   } vec_t;

   logic         clk;
   logic         rst;
   logic [255:0] data_in;
   logic         wr_en;
   logic [5:0]   host_write_addr;
   logic [5:0]   host_read_addr;
   logic [1:0]   mod;
   logic [5:0]   burst_len;
   logic         en_read;
   logic [255:0] out_number;
   logic         out_valid;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl[$];

   vector_uram_bank #(
      .DATA_W (256),
      .ADDR_W (6),
      .RD_LAT (2),
      .LANE_W (64)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .data_in         (data_in),
      .wr_en           (wr_en),
      .host_write_addr (host_write_addr),
      .host_read_addr  (host_read_addr),
      .mod             (mod),
      .burst_len       (burst_len),
      .en_read         (en_read),
      .out_number      (out_number),
      .out_valid       (out_valid),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic wr, input logic [5:0] wa, input logic [255:0] wd,
                               input logic [5:0] ra, input logic [1:0] md, input logic [5:0] bl,
                               input logic en, input logic ev, input logic eb, input logic ed,
                               input logic cd, input logic [255:0] edat);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.ra = ra; v.md = md; v.bl = bl; v.en = en;
      v.ev = ev; v.eb = eb; v.ed = ed; v.cd = cd; v.edat = edat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_ctl(input string nm, input logic ev, input logic eb, input logic ed);
      chk({nm, ".out_valid"}, {255'b0, out_valid}, {255'b0, ev});
      chk({nm, ".busy"},      {255'b0, busy},      {255'b0, eb});
      chk({nm, ".done"},      {255'b0, done},      {255'b0, ed});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; data_in = '0; wr_en = 1'b0; host_write_addr = '0; host_read_addr = '0;
      mod = 2'd1; burst_len = '0; en_read = 1'b0;

      // writes, direct reads, read-first collision
      tbl.push_back(mk(1, 1,  D1,  0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 2,  D2,  0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 3,  D3,  0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 4,  D4,  0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 5,  R,   0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 6,  R,   0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 0,  D0,  0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 63, D63, 0, 1, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(0, 0,  Z,   2, 0, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(1, 2,  ONE, 2, 0, 0, 0, 0, 0, 0, 1, Z));
      tbl.push_back(mk(0, 0,  Z,   2, 0, 0, 0, 1, 0, 0, 1, D2));
      tbl.push_back(mk(0, 0,  Z,   2, 1, 0, 0, 1, 0, 0, 1, D2));
      tbl.push_back(mk(0, 0,  Z,   2, 1, 0, 0, 1, 0, 0, 1, ONE));
      tbl.push_back(mk(0, 0,  Z,   2, 1, 0, 0, 0, 0, 0, 1, ONE));
      // INC burst from 1, 4 beats; addr2 rewritten before it is issued; second en_read ignored
      tbl.push_back(mk(0, 0,  Z,   1, 1, 3, 1, 0, 0, 0, 1, ONE));
      tbl.push_back(mk(1, 2,  D2,  9, 2, 0, 0, 0, 1, 0, 1, ONE));
      tbl.push_back(mk(0, 0,  Z,   9, 2, 0, 1, 0, 1, 0, 1, ONE));
      tbl.push_back(mk(0, 0,  Z,   9, 2, 0, 0, 1, 1, 0, 1, D1));
      tbl.push_back(mk(0, 0,  Z,   9, 2, 0, 0, 1, 1, 0, 1, D2));
      tbl.push_back(mk(0, 0,  Z,   9, 2, 0, 0, 1, 1, 0, 1, D3));
      tbl.push_back(mk(0, 0,  Z,   9, 2, 0, 0, 1, 1, 1, 1, D4));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 0, 0, 0, 1, D4));
      // DEC burst from 1, 3 beats, wraps to 63
      tbl.push_back(mk(0, 0,  Z,   1, 2, 2, 1, 0, 0, 0, 1, D4));
      tbl.push_back(mk(0, 0,  Z,   5, 0, 0, 0, 0, 1, 0, 1, D4));
      tbl.push_back(mk(0, 0,  Z,   5, 3, 0, 1, 0, 1, 0, 1, D4));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 1, 1, 0, 1, D1));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 1, 1, 0, 1, D0));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 1, 1, 1, 1, D63));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 0, 0, 0, 1, D63));
      // ROT burst from 5, 2 beats
      tbl.push_back(mk(0, 0,  Z,   5, 3, 1, 1, 0, 0, 0, 1, D63));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 0, 1, 0, 1, D63));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 0, 1, 0, 1, D63));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 1, 1, 0, 1, R));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 1, 1, 1, 1, RR));
      tbl.push_back(mk(0, 0,  Z,   0, 1, 0, 0, 0, 0, 0, 1, RR));

      // reset held for two cycles
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk_ctl($sformatf("reset%0d", c), 1'b0, 1'b0, 1'b0);
         chk($sformatf("reset%0d.out_number", c), out_number, Z);
      end
      step();
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step();
         wr_en = tbl[i].wr; host_write_addr = tbl[i].wa; data_in = tbl[i].wd;
         host_read_addr = tbl[i].ra; mod = tbl[i].md; burst_len = tbl[i].bl; en_read = tbl[i].en;
         @(negedge clk);
         chk_ctl($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].ed);
         if (tbl[i].cd) begin
            chk($sformatf("vec%0d.out_number", i), out_number, tbl[i].edat);
         end
      end

      // INC burst of 8 beats, reset dropped while beat 2 is on the output
      step();
      wr_en = 1'b0; mod = 2'd1; host_read_addr = 6'd1; burst_len = 6'd7; en_read = 1'b1;
      step();
      en_read = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("midrst.beat0", out_number, D1);
      step();
      @(negedge clk);
      chk("midrst.beat1", out_number, D2);
      step();
      @(negedge clk);
      chk_ctl("midrst.beat2", 1'b1, 1'b1, 1'b0);
      chk("midrst.beat2.out_number", out_number, D3);
      #1;
      rst = 1'b0;
      #1;
      chk_ctl("midrst.assert", 1'b0, 1'b0, 1'b0);
      chk("midrst.assert.out_number", out_number, Z);
      step();
      @(negedge clk);
      chk_ctl("midrst.held", 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b1; mod = 2'd1; host_read_addr = 6'd4;
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         chk_ctl($sformatf("postrst%0d", c), 1'b0, 1'b0, 1'b0);
      end

      // direct reads resume with memory intact
      step();
      mod = 2'd0; host_read_addr = 6'd4;
      step();
      host_read_addr = 6'd3;
      step();
      host_read_addr = 6'd6;
      @(negedge clk);
      chk_ctl("resume0", 1'b1, 1'b0, 1'b0);
      chk("resume0.out_number", out_number, D4);
      step();
      @(negedge clk);
      chk("resume1.out_number", out_number, D3);
      step();
      @(negedge clk);
      chk("resume2.out_number", out_number, R);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
